// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan
// Description : Registered SEL_W-to-2**SEL_W one-hot decoder with two modes.
//               Direct mode decodes sel_i one clock later. Scan mode steps
//               through every output in turn, holding each one for DIV
//               clocks, and pulses wrap_o when the index rolls over to 0.
//               Intended for digit/LED/row select lines in display and
//               keypad scan circuits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SEL_W   : select width, 1..5; output width OUTS = 2**SEL_W
//   DIV     : scan dwell in clocks per output, >= 1
//   ACT_LOW : 1 = y_o active-low, including its reset/idle value
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous reset, active-high
//   en_i    in   1      enable; 0 = all outputs inactive
//   mode_i  in   1      0 = direct decode, 1 = scan
//   sel_i   in   SEL_W  direct index; scan start index on scan entry
//   y_o     out  OUTS   one-hot select outputs (polarity per ACT_LOW)
//   idx_o   out  SEL_W  index currently decoded onto y_o
//   wrap_o  out  1      one-clock pulse when the scan index wraps to 0
// ============================================================================
module decoder_scan #(
   parameter int SEL_W   = 2,
   parameter int DIV     = 4,
   parameter int ACT_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en_i,
   input  logic                    mode_i,
   input  logic [SEL_W-1:0]        sel_i,
   output logic [(1<<SEL_W)-1:0]   y_o,
   output logic [SEL_W-1:0]        idx_o,
   output logic                    wrap_o
);

   localparam int OUTS  = 1 << SEL_W;
   // A one-clock dwell still needs a 1-bit counter to keep the logic uniform.
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CNT_W-1:0] C_DIV_M1 = CNT_W'(DIV - 1);
   // Inactive output pattern; XOR with it applies the output polarity.
   localparam logic [OUTS-1:0]  C_Y_IDLE = (ACT_LOW != 0) ? {OUTS{1'b1}} : {OUTS{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   idx_q,   idx_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               wrap_q,  wrap_d;
   logic [OUTS-1:0]    y_q,     y_d;

   function automatic logic [OUTS-1:0] f_onehot(input logic [SEL_W-1:0] s);
      logic [OUTS-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

   // ------------------------------------------------------------------------
   // Next-state logic. All outputs are derived from the next index so that
   // y_o always matches idx_o in the same cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = '0;
      wrap_d  = 1'b0;
      y_d     = C_Y_IDLE;

      if (!en_i) begin
         // Idle: outputs off, index retained for observation.
         state_d = ST_IDLE;
      end else if (!mode_i) begin
         state_d = ST_DIRECT;
         idx_d   = sel_i;
         y_d     = f_onehot(idx_d) ^ C_Y_IDLE;
      end else begin
         state_d = ST_SCAN;
         if (state_q != ST_SCAN) begin
            // Entry edge: load the start index and begin a full dwell.
            idx_d = sel_i;
         end else if (cnt_q == C_DIV_M1) begin
            // Dwell complete: advance with natural SEL_W rollover.
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == {SEL_W{1'b1}});
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         y_d = f_onehot(idx_d) ^ C_Y_IDLE;
      end
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         y_q     <= C_Y_IDLE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         y_q     <= y_d;
      end
   end

   assign y_o    = y_q;
   assign idx_o  = idx_q;
   assign wrap_o = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_scan
// Description : Self-checking bench for decoder_scan. Instance u_dut0 uses
//               SEL_W=2, DIV=4, active-high; u_dut1 uses SEL_W=3, DIV=1,
//               active-low. Table-driven vectors plus hand-written reset and
//               scan sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       en0 = 1'b0, mode0 = 1'b0;
   logic [1:0] sel0 = '0;
   logic [3:0] y0;
   logic [1:0] idx0;
   logic       wrap0;

   logic       en1 = 1'b0, mode1 = 1'b0;
   logic [2:0] sel1 = '0;
   logic [7:0] y1;
   logic [2:0] idx1;
   logic       wrap1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decoder_scan #(.SEL_W(2), .DIV(4), .ACT_LOW(0)) u_dut0 (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en0),
      .mode_i (mode0),
      .sel_i  (sel0),
      .y_o    (y0),
      .idx_o  (idx0),
      .wrap_o (wrap0)
   );

   decoder_scan #(.SEL_W(3), .DIV(1), .ACT_LOW(1)) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en1),
      .mode_i (mode1),
      .sel_i  (sel1),
      .y_o    (y1),
      .idx_o  (idx1),
      .wrap_o (wrap1)
   );

   typedef struct {
      logic       en;
      logic       mode;
      logic [1:0] sel;
      logic [3:0] y;
      logic [1:0] idx;
      logic       wrap;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h expected=%0h", nm, n, act, exp);
      end
   endtask

   task automatic add(input logic e, input logic m, input logic [1:0] s,
                      input logic [1:0] ix, input logic w, input logic on);
      vec_t    v;
      logic [3:0] one;
      one    = 4'b0001;
      v.en   = e;
      v.mode = m;
      v.sel  = s;
      v.idx  = ix;
      v.wrap = w;
      v.y    = on ? (one << ix) : 4'b0000;
      vecs.push_back(v);
   endtask

   // Step u_dut0 one clock and compare all three outputs.
   task automatic step0(input string nm, input int n, input logic [3:0] ey,
                        input logic [1:0] ei, input logic ew);
      @(posedge clk);
      #1;
      chk({nm, "_y"},    n, 32'(y0),    32'(ey));
      chk({nm, "_idx"},  n, 32'(idx0),  32'(ei));
      chk({nm, "_wrap"}, n, 32'(wrap0), 32'(ew));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] e8;
      logic [7:0] one8;
      one8 = 8'h01;

      // ---------------- reset values (asynchronous, before any edge) -----
      #1 rst = 1'b1;
      #1;
      chk("rst0_y",    0, 32'(y0),    32'h0);
      chk("rst0_idx",  0, 32'(idx0),  32'h0);
      chk("rst0_wrap", 0, 32'(wrap0), 32'h0);
      chk("rst1_y",    0, 32'(y1),    32'hFF);
      chk("rst1_idx",  0, 32'(idx1),  32'h0);
      chk("rst1_wrap", 0, 32'(wrap1), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // ---------------- table: direct, idle, scan, mode switching --------
      add(1, 0, 2'd2, 2'd2, 0, 1);
      add(1, 0, 2'd3, 2'd3, 0, 1);
      add(0, 0, 2'd1, 2'd3, 0, 0);   // disable: outputs off, idx held
      add(1, 0, 2'd1, 2'd1, 0, 1);
      add(1, 0, 2'd0, 2'd0, 0, 1);   // direct load of 0 is not a wrap
      // scan entry at sel=1; later sel changes must be ignored
      for (int k = 0; k < 17; k++)
         add(1, 1, (k == 0) ? 2'd1 : 2'd3, 2'((1 + k / 4) % 4), (k == 12), 1);
      add(1, 0, 2'd2, 2'd2, 0, 1);   // leave scan mid-dwell
      // re-enter scan at sel=3: full dwell, then wrap to 0
      for (int k = 0; k < 5; k++)
         add(1, 1, (k == 0) ? 2'd3 : 2'd1, (k < 4) ? 2'd3 : 2'd0, (k == 4), 1);
      add(0, 1, 2'd1, 2'd0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         en0   = vecs[i].en;
         mode0 = vecs[i].mode;
         sel0  = vecs[i].sel;
         step0("vec", i, vecs[i].y, vecs[i].idx, vecs[i].wrap);
      end

      // ---------------- reset mid-scan, between edges -------------------
      en0 = 1'b1; mode0 = 1'b1; sel0 = 2'd3;
      for (int k = 0; k < 4; k++)
         step0("pre", k, 4'b1000, 2'd3, 1'b0);
      step0("prewrap", 0, 4'b0001, 2'd0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_y",    0, 32'(y0),    32'h0);
      chk("midrst_idx",  0, 32'(idx0),  32'h0);
      chk("midrst_wrap", 0, 32'(wrap0), 32'h0);
      chk("midrst1_y",   0, 32'(y1),    32'hFF);
      sel0 = 2'd2;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++)
         step0("restart", k, 4'b0100, 2'd2, 1'b0);
      step0("restart_adv", 0, 4'b1000, 2'd3, 1'b0);
      en0 = 1'b0;

      // ---------------- active-low, SEL_W=3, DIV=1 -----------------------
      en1 = 1'b1; mode1 = 1'b0;
      for (int s = 0; s < 8; s++) begin
         sel1 = 3'(s);
         @(posedge clk);
         #1;
         e8 = ~(one8 << s);
         chk("al_dir_y",   s, 32'(y1),   32'(e8));
         chk("al_dir_idx", s, 32'(idx1), 32'(s));
      end
      mode1 = 1'b1; sel1 = 3'd0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         e8 = ~(one8 << (k % 8));
         chk("al_scan_y",    k, 32'(y1),    32'(e8));
         chk("al_scan_idx",  k, 32'(idx1),  32'(k % 8));
         chk("al_scan_wrap", k, 32'(wrap1), 32'((k > 0) && (k % 8 == 0)));
      end
      en1 = 1'b0;
      @(posedge clk);
      #1;
      chk("al_off_y", 0, 32'(y1), 32'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
